// File: rtl/enigma_pkg.sv
// Shared types and wiring tables for the three-rotor Enigma I cipher core.
// Each table is a packed ASCII string: character i is the output for input letter i.
package enigma_pkg;

  typedef logic [4:0] letter_t;

  typedef enum logic [3:0] {IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R} state_t;

  localparam logic [1:0] SEL_I   = 2'd0;
  localparam logic [1:0] SEL_II  = 2'd1;
  localparam logic [1:0] SEL_III = 2'd2;
  localparam logic [1:0] SEL_UKW = 2'd3;

  localparam letter_t NOTCH_II  = 5'd4;
  localparam letter_t NOTCH_III = 5'd21;

  localparam logic [207:0] ROTOR_I_FWD   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] ROTOR_I_INV   = "UWYGADFPVZBECKMTHXSLRINQOJ";
  localparam logic [207:0] ROTOR_II_FWD  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] ROTOR_II_INV  = "AJPCZWRLFBDKOTYUQGENHXMIVS";
  localparam logic [207:0] ROTOR_III_FWD = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
  localparam logic [207:0] ROTOR_III_INV = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
  localparam logic [207:0] UKW_B         = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  // idx must already be reduced to 0..25
  function automatic letter_t tbl_at(input logic [207:0] tbl, input letter_t idx);
    logic [7:0] ch;
    ch = tbl[8*(25-int'(idx)) +: 8];
    return letter_t'(ch - 8'd65);
  endfunction

  // Single conditional subtract; callers keep the input below 52
  function automatic letter_t mod26(input logic [5:0] v);
    return (v >= 6'd26) ? letter_t'(v - 6'd26) : letter_t'(v);
  endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// One offset rotor (or reflector) substitution: (W[(c+p) mod 26] - p) mod 26.
module enigma_rotor_map
  import enigma_pkg::*;
(
  input  logic [4:0] letter,
  input  logic [4:0] offset,
  input  logic [1:0] sel,
  input  logic       inv,
  output logic [4:0] mapped
);

  logic [5:0] sum;
  logic [5:0] diff;
  letter_t    idx;
  letter_t    wired;

  always_comb begin
    sum = {1'b0, letter} + {1'b0, offset};
    idx = mod26(sum);
    case (sel)
      SEL_I:   wired = tbl_at(inv ? ROTOR_I_INV   : ROTOR_I_FWD,   idx);
      SEL_II:  wired = tbl_at(inv ? ROTOR_II_INV  : ROTOR_II_FWD,  idx);
      SEL_III: wired = tbl_at(inv ? ROTOR_III_INV : ROTOR_III_FWD, idx);
      default: wired = tbl_at(UKW_B, idx);
    endcase
    // bias by 26 so the subtraction never goes negative
    diff   = {1'b0, wired} + 6'd26 - {1'b0, offset};
    mapped = mod26(diff);
  end

endmodule

// File: rtl/enigma_cipher_core.sv
// Sequential Enigma I (rotors I-II-III, UKW-B) cipher: one substitution per cycle,
// result 8 edges after accept; a single shared rotor_map serves every pass.
module enigma_cipher_core
  import enigma_pkg::*;
#(
  parameter int          LETTER_W = 5,
  parameter logic [14:0] INIT_POS = 15'd0
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                valid_in,
  input  logic                load_in,
  input  logic [14:0]         pos_in,
  output logic [LETTER_W-1:0] code_letter_out,
  output logic                valid_out,
  output logic                busy_out,
  output logic                err_out,
  output logic [14:0]         pos_out
);

  state_t     state, state_nxt;
  letter_t    c, mapped;
  letter_t    pos_l, pos_m, pos_r;
  logic [4:0] off;
  logic [1:0] sel;
  logic       inv, accept, reject, do_load;

  enigma_rotor_map u_map (
    .letter (c),
    .offset (off),
    .sel    (sel),
    .inv    (inv),
    .mapped (mapped)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    do_load   = 1'b0;
    sel       = SEL_III;
    inv       = 1'b0;
    off       = pos_r;
    case (state)
      IDLE: begin
        if (load_in) do_load = 1'b1;
        else if (valid_in) begin
          if (letter_in <= LETTER_W'(25)) begin
            accept    = 1'b1;
            state_nxt = STEP;
          end else reject = 1'b1;
        end
      end
      STEP: state_nxt = F_R;
      F_R:  state_nxt = F_M;
      F_M:  begin sel = SEL_II; off = pos_m; state_nxt = F_L; end
      F_L:  begin sel = SEL_I;  off = pos_l; state_nxt = REFL; end
      REFL: begin sel = SEL_UKW; off = 5'd0; state_nxt = B_L; end
      B_L:  begin sel = SEL_I;  off = pos_l; inv = 1'b1; state_nxt = B_M; end
      B_M:  begin sel = SEL_II; off = pos_m; inv = 1'b1; state_nxt = B_R; end
      B_R:  begin inv = 1'b1; state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && valid_in) reject = 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      c               <= '0;
      pos_l           <= INIT_POS[14:10];
      pos_m           <= INIT_POS[9:5];
      pos_r           <= INIT_POS[4:0];
      code_letter_out <= '0;
      valid_out       <= 1'b0;
      busy_out        <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      err_out   <= reject;
      if (do_load) begin
        pos_l <= mod26({1'b0, pos_in[14:10]});
        pos_m <= mod26({1'b0, pos_in[9:5]});
        pos_r <= mod26({1'b0, pos_in[4:0]});
      end
      if (accept) begin
        c        <= letter_t'(letter_in);
        busy_out <= 1'b1;
      end
      // stepping uses pre-step values, which yields the middle-rotor double step
      if (state == STEP) begin
        pos_r <= (pos_r == 5'd25) ? 5'd0 : pos_r + 5'd1;
        if (pos_r == NOTCH_III || pos_m == NOTCH_II)
          pos_m <= (pos_m == 5'd25) ? 5'd0 : pos_m + 5'd1;
        if (pos_m == NOTCH_II)
          pos_l <= (pos_l == 5'd25) ? 5'd0 : pos_l + 5'd1;
      end
      if (state != IDLE && state != STEP) c <= mapped;
      if (state == B_R) begin
        code_letter_out <= LETTER_W'(mapped);
        valid_out       <= 1'b1;
        busy_out        <= 1'b0;
      end
    end
  end

  assign pos_out = {pos_l, pos_m, pos_r};

endmodule

// File: tb/tb_enigma_cipher_core.sv
// Randomized and directed checks of enigma_cipher_core against a letter-level Enigma model.
module tb_enigma_cipher_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  letter_in = '0;
  logic        valid_in = 1'b0;
  logic        load_in = 1'b0;
  logic [14:0] pos_in = '0;
  logic [4:0]  code;
  logic        valid_out, busy_out, err_out;
  logic [14:0] pos_out;

  enigma_cipher_core #(.LETTER_W(5), .INIT_POS(15'd0)) dut (
    .clk_in(clk), .rst_in(rst), .letter_in(letter_in), .valid_in(valid_in),
    .load_in(load_in), .pos_in(pos_in), .code_letter_out(code),
    .valid_out(valid_out), .busy_out(busy_out), .err_out(err_out), .pos_out(pos_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: rotor positions and wiring as letter strings
  string ROT[3] = '{"EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
                    "BDFHJLCPRTXVZNYEIWGAKMUSQO"};
  string UKW = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  int m_l = 0, m_m = 0, m_r = 0;
  int busy_end = 0;

  int exp_code[$], exp_due[$], exp_in[$], err_due[$], got[$];

  function automatic void chk(bit ok, string name, int act, int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int wire_f(int r, int x);
    return int'(ROT[r][x]) - 65;
  endfunction

  function automatic int wire_b(int r, int y);
    for (int x = 0; x < 26; x++) if (wire_f(r, x) == y) return x;
    return -1;
  endfunction

  function automatic int through(int r, int c, int p, bit back);
    int w;
    w = back ? wire_b(r, (c + p) % 26) : wire_f(r, (c + p) % 26);
    return (w - p + 26) % 26;
  endfunction

  function automatic void step_model();
    bit adv_m, adv_l;
    adv_m = (m_r == 21) || (m_m == 4);
    adv_l = (m_m == 4);
    m_r = (m_r + 1) % 26;
    if (adv_m) m_m = (m_m + 1) % 26;
    if (adv_l) m_l = (m_l + 1) % 26;
  endfunction

  function automatic int encipher(int x);
    int c;
    c = through(2, x, m_r, 0);
    c = through(1, c, m_m, 0);
    c = through(0, c, m_l, 0);
    c = int'(UKW[c]) - 65;
    c = through(0, c, m_l, 1);
    c = through(1, c, m_m, 1);
    return through(2, c, m_r, 1);
  endfunction

  function automatic int mpos();
    return m_l * 1024 + m_m * 32 + m_r;
  endfunction

  // compare process: every result and every error pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_out) begin
        if (exp_code.size() == 0) chk(0, "valid_unexpected", 1, 0);
        else begin
          chk(int'(code) == exp_code[0], "code_letter", int'(code), exp_code[0]);
          chk(cyc == exp_due[0], "latency", cyc, exp_due[0]);
          chk(int'(code) != exp_in[0], "no_self_map", int'(code), exp_in[0]);
          got.push_back(int'(code));
          void'(exp_code.pop_front()); void'(exp_due.pop_front()); void'(exp_in.pop_front());
        end
      end else if (exp_due.size() > 0 && cyc >= exp_due[0]) begin
        chk(0, "valid_missing", 0, 1);
        void'(exp_code.pop_front()); void'(exp_due.pop_front()); void'(exp_in.pop_front());
      end
      if (err_out) begin
        if (err_due.size() == 0) chk(0, "err_unexpected", 1, 0);
        else begin
          chk(cyc == err_due[0], "err_timing", cyc, err_due[0]);
          void'(err_due.pop_front());
        end
      end else if (err_due.size() > 0 && cyc >= err_due[0]) begin
        chk(0, "err_missing", 0, 1);
        void'(err_due.pop_front());
      end
    end
  end

  // one input cycle, called at a negedge; predicts what the core must do
  task automatic drive(bit v, int l, bit ld, int pl, int pm, int pr);
    bit idle;
    idle = (cyc >= busy_end);
    chk(busy_out == !idle, "busy", int'(busy_out), int'(!idle));
    if (idle) chk(int'(pos_out) == mpos(), "pos", int'(pos_out), mpos());
    valid_in  = v;
    letter_in = 5'(l);
    load_in   = ld;
    pos_in    = {5'(pl), 5'(pm), 5'(pr)};
    if (idle) begin
      if (ld) begin
        m_l = pl % 26; m_m = pm % 26; m_r = pr % 26;
      end else if (v) begin
        if (l <= 25) begin
          step_model();
          exp_code.push_back(encipher(l));
          exp_due.push_back(cyc + 9);
          exp_in.push_back(l);
          busy_end = cyc + 9;
        end else err_due.push_back(cyc + 1);
      end
    end else if (v) err_due.push_back(cyc + 1);
    @(negedge clk);
    valid_in = 1'b0;
    load_in  = 1'b0;
  endtask

  task automatic wait_done();
    while (cyc < busy_end) @(negedge clk);
  endtask

  task automatic send_word(input int w[], output int outw[]);
    got.delete();
    foreach (w[i]) begin
      drive(1, w[i], 0, 0, 0, 0);
      wait_done();
    end
    @(negedge clk);
    outw = new[w.size()];
    foreach (outw[i]) outw[i] = (i < got.size()) ? got[i] : -1;
  endtask

  initial begin
    int bdzgo[5] = '{1, 3, 25, 6, 14};
    int adu[3]   = '{(0*1024 + 3*32 + 21), (0*1024 + 4*32 + 22), (1*1024 + 5*32 + 23)};
    int hello[]  = '{7, 4, 11, 11, 14};
    int ones[]   = '{0, 0, 0, 0, 0};
    int xw[], back[];
    int k;

    // reset state
    repeat (2) @(negedge clk);
    chk(pos_out == 15'd0, "rst_pos", int'(pos_out), 0);
    chk(code == 5'd0, "rst_code", int'(code), 0);
    chk(valid_out == 1'b0, "rst_valid", int'(valid_out), 0);
    chk(busy_out == 1'b0, "rst_busy", int'(busy_out), 0);
    chk(err_out == 1'b0, "rst_err", int'(err_out), 0);
    rst = 1'b0;
    busy_end = cyc;

    // AAAAA from AAA -> BDZGO, ends at AAF
    send_word(ones, xw);
    foreach (bdzgo[i]) chk(xw[i] == bdzgo[i], "bdzgo", xw[i], bdzgo[i]);
    chk(pos_out == 15'd5, "pos_aaf", int'(pos_out), 5);

    // double step from ADU
    drive(0, 0, 1, 0, 3, 20);
    for (int i = 0; i < 3; i++) begin
      drive(1, i, 0, 0, 0, 0);
      wait_done();
      @(negedge clk);
      chk(int'(pos_out) == adu[i], "double_step", int'(pos_out), adu[i]);
    end

    // reciprocity
    drive(0, 0, 1, 0, 0, 0);
    send_word(hello, xw);
    drive(0, 0, 1, 0, 0, 0);
    send_word(xw, back);
    foreach (hello[i]) chk(back[i] == hello[i], "reciprocity", back[i], hello[i]);

    // bad letter in idle, valid while busy, load while busy, load beats valid, load reduced mod 26
    drive(1, 27, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 9, 0, 0, 0, 0);
    drive(1, 5, 0, 0, 0, 0);
    drive(0, 0, 1, 7, 7, 7);
    wait_done();
    drive(1, 3, 1, 30, 26, 31);
    drive(0, 0, 0, 0, 0, 0);
    chk(pos_out == {5'd4, 5'd0, 5'd5}, "load_mod26", int'(pos_out), 4*1024 + 5);

    // back-to-back: second request in the valid_out cycle
    drive(1, 12, 0, 0, 0, 0);
    wait_done();
    chk(valid_out == 1'b1, "b2b_valid", int'(valid_out), 1);
    drive(1, 13, 0, 0, 0, 0);
    wait_done();

    // async reset while in F_M
    drive(1, 2, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    exp_code.delete(); exp_due.delete(); exp_in.delete(); err_due.delete();
    #1;
    chk(pos_out == 15'd0, "midrst_pos", int'(pos_out), 0);
    chk(busy_out == 1'b0, "midrst_busy", int'(busy_out), 0);
    chk(valid_out == 1'b0, "midrst_valid", int'(valid_out), 0);
    @(negedge clk);
    rst = 1'b0;
    m_l = 0; m_m = 0; m_r = 0;
    busy_end = cyc;
    repeat (12) drive(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 55)      drive(1, $urandom_range(0, 29), 0, 0, 0, 0);
      else if (k < 65) drive(0, 0, 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      else if (k < 70) drive(1, $urandom_range(0, 31), 1, $urandom_range(0, 25), $urandom_range(0, 25), $urandom_range(0, 25));
      else             drive(0, 0, 0, 0, 0, 0);
    end
    wait_done();
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    chk(exp_code.size() == 0, "drain", exp_code.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/enigma_cipher_core.md
Name: enigma_cipher_core

Overview:
- Computes the cipher for one Enigma letter.
- Models a three-rotor Enigma I: rotors I (left), II (middle), III (right), reflector B, all ring settings at A, no plugboard.
- Sits directly upstream of enigma_display. It takes a plaintext letter index from the switch/debounce path and produces the code letter that enigma_display renders.
- It also exports the live rotor positions so they can be displayed.

Parameters:
- LETTER_W, 5, width of a letter index (0=A .. 25=Z).
- INIT_POS, 15'd0, reset rotor positions packed {left, middle, right}, 5 bits each.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous reset, active-high.
- letter_in  input  LETTER_W  plaintext letter index.
- valid_in  input  1  one-cycle request to encipher letter_in.
- load_in  input  1  one-cycle request to load rotor positions from pos_in.
- pos_in  input  15  {left, middle, right} start positions.
- code_letter_out  output  LETTER_W  enciphered letter, held until the next result.
- valid_out  output  1  one-cycle pulse when code_letter_out updates.
- busy_out  output  1  high while a letter is in flight.
- err_out  output  1  one-cycle pulse when a request is rejected.
- pos_out  output  15  current rotor positions {left, middle, right}.

Behaviour:
- Reset (async assert, sync deassert by design intent):
  - state=IDLE; pos_out=INIT_POS; code_letter_out=0; valid_out=0; busy_out=0; err_out=0.
- FSM states: IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R. Exactly one substitution is performed per cycle.
- IDLE, valid_in=1 with letter_in<=25:
  - Latch the letter into a working register; busy_out<=1; go to STEP.
  - This clock edge is the "accept edge".
- IDLE, valid_in=1 with letter_in 26..31:
  - err_out pulses for one cycle.
  - No stepping; state remains IDLE.
- IDLE, load_in=1: pos_out<=pos_in. If valid_in is also high in the same cycle, load wins and valid_in is ignored (no err).
- load_in outside IDLE: ignored.
- valid_in outside IDLE: ignored, err_out pulses once. There is no queuing.
- pos_in field values above 25: reduced mod 26 on load.
- STEP (stepping happens before encipherment, with double-step):
  - Right rotor always advances.
  - Middle rotor advances if right==21 (V, rotor III notch) or middle==4 (E, rotor II notch).
  - Left rotor advances if middle==4 (Q notch of rotor I is unused because there is no fourth rotor).
  - All advances wrap 25->0.
- F_R, F_M, F_L: c <= (W_k[(c+p_k) mod 26] - p_k) mod 26, where p_k is the rotor position already updated by STEP.
- REFL: c <= UKW_B[c].
- B_L, B_M, B_R: the same formula using the inverse wiring table.
- Mod-26 arithmetic uses a 6-bit intermediate with a single conditional subtract/add. No divider.
- Completion: on the edge leaving B_R:
  - code_letter_out<=c; valid_out<=1; busy_out<=0; state<=IDLE.
  - This is 8 clock edges after the accept edge; valid_out is high in the following cycle only.
- A new valid_in may be accepted in the same cycle that valid_out is high (back-to-back throughput: 1 letter per 9 cycles).
- Reset mid-operation: the in-flight letter is discarded, no valid_out is emitted, and positions return to INIT_POS.

Decomposition:
- enigma_pkg holds:
  - letter_t typedef.
  - Constant arrays ROTOR_I/II/III forward and inverse.
  - UKW_B.
  - Notch constants NOTCH_II=4 and NOTCH_III=21.
  - State enum.
- Sub-module enigma_rotor_map (combinational). Inputs: letter, offset, rotor select, direction. Output: substituted letter. One instance is shared across all substitution states.

Test Plan:
- Reset, pos=AAA, send A five times (waiting for valid_out each time) -> code letters B,D,Z,G,O; pos_out ends at AAF.
- load_in pos_in={0,3,20} (ADU), send three letters -> pos_out after each is ADV, AEW, BFX (double step).
- Reciprocity: load AAA, encipher 'HELLO' -> outputs X; reload AAA and encipher X -> 'HELLO'; no letter ever maps to itself.
- letter_in=27 in IDLE -> err_out pulses 1 cycle, no valid_out, pos_out unchanged. valid_in during busy -> err_out pulse, result of the original letter is unaffected.
- Latency/back-to-back: valid_out exactly 8 edges after the accept edge; a second valid_in asserted in the valid_out cycle is accepted.
- Assert rst_in in state F_M -> outputs reset immediately (asynchronously); no valid_out is emitted afterwards; pos_out=INIT_POS.
